// File: rtl/boa_mul_iter.sv
// boa_mul_iter: iterative shift-add multiplier for the MUL/MULH/MULHSU/MULHU family.
// The operands are converted to magnitudes. Each BUSY cycle retires bpc multiplier
// bits. A FIX cycle applies the result sign, and DONE holds the result until it is
// consumed.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   flush             synchronous cancel of any operation in flight
//   d_valid/d_ready   operand handshake (lhs, rhs, u_lhs, u_rhs)
//   q_valid/q_ready   result handshake (q_res, 2*width bits)
//
// state  | meaning
// IDLE   | ready for operands
// BUSY   | accumulating partial products, width/bpc cycles
// FIX    | applying the result sign into q_res
// DONE   | result valid, waiting for q_ready
module boa_mul_iter #(
    parameter int width = 32,
    parameter int bpc   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 d_valid,
    output logic                 d_ready,
    input  logic                 u_lhs,
    input  logic                 u_rhs,
    input  logic [width-1:0]     lhs,
    input  logic [width-1:0]     rhs,
    output logic                 q_valid,
    input  logic                 q_ready,
    output logic [2*width-1:0]   q_res
);
    localparam int ITERS = width / bpc;
    localparam int CW    = $clog2(ITERS + 1);
    localparam logic [width-1:0]   ONE_W  = 1;
    localparam logic [2*width-1:0] ONE_2W = 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [2*width-1:0]   r_acc;
    logic [2*width-1:0]   r_mcand;
    logic [width-1:0]     r_mplr;
    logic                 r_neg;
    logic [CW-1:0]        r_iter;
    logic [2*width-1:0]   r_q_res;

    logic                 w_sign_lhs;
    logic                 w_sign_rhs;
    logic [width-1:0]     w_lhs_mag;
    logic [width-1:0]     w_rhs_mag;
    logic                 w_load;
    logic [2*width-1:0]   w_pp;

    assign w_sign_lhs = !u_lhs && lhs[width-1];
    assign w_sign_rhs = !u_rhs && rhs[width-1];
    // The most negative value negates to itself, which is its correct magnitude
    // when it is read as unsigned.
    assign w_lhs_mag  = w_sign_lhs ? (~lhs + ONE_W) : lhs;
    assign w_rhs_mag  = w_sign_rhs ? (~rhs + ONE_W) : rhs;
    assign w_load     = (r_state == S_IDLE) && d_valid && !flush;

    // Multiplicand times the low bpc multiplier bits, formed by shift-add so that
    // no hard multiplier is inferred.
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < bpc; j++) begin
            if (r_mplr[j]) begin
                w_pp = w_pp + (r_mcand << j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        d_ready = 1'b0;
        q_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                d_ready = 1'b1;
                if (w_load) w_next = S_BUSY;
            end
            S_BUSY: begin
                if (r_iter == CW'(1)) w_next = S_FIX;
            end
            S_FIX: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                q_valid = 1'b1;
                if (q_ready) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_neg   <= 1'b0;
            r_iter  <= '0;
            r_q_res <= '0;
        end else begin
            if (w_load) begin
                r_acc   <= '0;
                r_mcand <= {{width{1'b0}}, w_lhs_mag};
                r_mplr  <= w_rhs_mag;
                r_neg   <= w_sign_lhs ^ w_sign_rhs;
                r_iter  <= CW'(ITERS);
            end else if (r_state == S_BUSY && !flush) begin
                r_acc   <= r_acc + w_pp;
                r_mcand <= r_mcand << bpc;
                r_mplr  <= r_mplr >> bpc;
                r_iter  <= r_iter - CW'(1);
            end
            // A flush during FIX leaves the previous result in place.
            if (r_state == S_FIX && !flush) begin
                r_q_res <= r_neg ? (~r_acc + ONE_2W) : r_acc;
            end
        end
    end

    assign q_res = r_q_res;

endmodule

// File: tb/tb_boa_mul_iter.sv
module tb_boa_mul_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance: width 32, bpc 1
    logic        fl32 = 0, dv32 = 0, ul32 = 0, ur32 = 0, qr32 = 0;
    logic [31:0] l32 = 0, r32 = 0;
    logic        dr32, qv32;
    logic [63:0] q32;
    // swept instance: width 16, bpc 4
    logic        fl16 = 0, dv16 = 0, ul16 = 0, ur16 = 0, qr16 = 0;
    logic [15:0] l16 = 0, r16 = 0;
    logic        dr16, qv16;
    logic [31:0] q16;

    boa_mul_iter #(.width(32), .bpc(1)) dut32 (
        .clk(clk), .rst(rst), .flush(fl32), .d_valid(dv32), .d_ready(dr32),
        .u_lhs(ul32), .u_rhs(ur32), .lhs(l32), .rhs(r32),
        .q_valid(qv32), .q_ready(qr32), .q_res(q32));

    boa_mul_iter #(.width(16), .bpc(4)) dut16 (
        .clk(clk), .rst(rst), .flush(fl16), .d_valid(dv16), .d_ready(dr16),
        .u_lhs(ul16), .u_rhs(ur16), .lhs(l16), .rhs(r16),
        .q_valid(qv16), .q_ready(qr16), .q_res(q16));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product: sign- or zero-extend each operand, multiply, keep 2w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic ua, input logic ub, input int w);
        logic [63:0] m, ea, eb;
        m  = (64'd1 << w) - 64'd1;
        ea = {32'd0, a} & m;
        eb = {32'd0, b} & m;
        if (!ua && a[w-1]) ea = ea | ~m;
        if (!ub && b[w-1]) eb = eb | ~m;
        return (ea * eb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Transaction-level model: an accepted operation yields its product
    // width/bpc + 1 edges later; the result holds until consumed. Flush drops everything.
    logic        m_busy32 = 0, m_done32 = 0, m_busy16 = 0, m_done16 = 0;
    int          m_cnt32 = 0, m_cnt16 = 0;
    logic [63:0] m_exp32 = 0, m_res32 = 0, m_exp16 = 0, m_res16 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy32 <= 0; m_done32 <= 0; m_res32 <= 0; m_cnt32 <= 0;
            m_busy16 <= 0; m_done16 <= 0; m_res16 <= 0; m_cnt16 <= 0;
        end else begin
            if (fl32) begin
                m_busy32 <= 0; m_done32 <= 0;
            end else if (m_done32) begin
                if (qr32) m_done32 <= 0;
            end else if (m_busy32) begin
                m_cnt32 <= m_cnt32 + 1;
                if (m_cnt32 + 1 == 33) begin
                    m_busy32 <= 0; m_done32 <= 1; m_res32 <= m_exp32;
                end
            end else if (dv32) begin
                m_busy32 <= 1; m_cnt32 <= 0;
                m_exp32 <= ref_mul(l32, r32, ul32, ur32, 32);
            end
            if (fl16) begin
                m_busy16 <= 0; m_done16 <= 0;
            end else if (m_done16) begin
                if (qr16) m_done16 <= 0;
            end else if (m_busy16) begin
                m_cnt16 <= m_cnt16 + 1;
                if (m_cnt16 + 1 == 5) begin
                    m_busy16 <= 0; m_done16 <= 1; m_res16 <= m_exp16;
                end
            end else if (dv16) begin
                m_busy16 <= 1; m_cnt16 <= 0;
                m_exp16 <= ref_mul({16'd0, l16}, {16'd0, r16}, ul16, ur16, 16);
            end
        end
    end

    always @(negedge clk) begin
        chk("q_valid32", {63'd0, qv32}, {63'd0, m_done32});
        chk("d_ready32", {63'd0, dr32}, {63'd0, !(m_busy32 || m_done32)});
        chk("q_res32", q32, m_res32);
        chk("q_valid16", {63'd0, qv16}, {63'd0, m_done16});
        chk("d_ready16", {63'd0, dr16}, {63'd0, !(m_busy16 || m_done16)});
        chk("q_res16", {32'd0, q16}, m_res16);
    end

    // Both op tasks start and end just after a falling edge.
    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic ua, input logic ub,
                        input int hold, output logic [63:0] res, output int lat);
        int k;
        chk("accept_ready32", {63'd0, dr32}, 64'd1);
        l32 = a; r32 = b; ul32 = ua; ur32 = ub; dv32 = 1;
        @(posedge clk);
        @(negedge clk);
        dv32 = 0; l32 = $urandom; r32 = $urandom; ul32 = $urandom; ur32 = $urandom;
        k = 0;
        while (!qv32 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("timeout32", 64'd0, 64'd1);
        res = q32;
        lat = k;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_qvalid32", {63'd0, qv32}, 64'd1);
            chk("bp_dready32", {63'd0, dr32}, 64'd0);
            chk("bp_hold32", q32, res);
        end
        qr32 = 1;
        @(negedge clk);
        qr32 = 0;
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ua, input logic ub,
                        input int hold, output logic [63:0] res, output int lat);
        int k;
        chk("accept_ready16", {63'd0, dr16}, 64'd1);
        l16 = a; r16 = b; ul16 = ua; ur16 = ub; dv16 = 1;
        @(posedge clk);
        @(negedge clk);
        dv16 = 0; l16 = 16'($urandom); r16 = 16'($urandom);
        k = 0;
        while (!qv16 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) chk("timeout16", 64'd0, 64'd1);
        res = {32'd0, q16};
        lat = k;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_hold16", {32'd0, q16}, res);
        end
        qr16 = 1;
        @(negedge clk);
        qr16 = 0;
    endtask

    initial begin
        logic [63:0] res;
        int lat;
        logic [31:0] a, b;
        logic ua, ub;

        repeat (2) @(negedge clk);
        chk("rst_dready", {63'd0, dr32}, 64'd1);
        chk("rst_qvalid", {63'd0, qv32}, 64'd0);
        chk("rst_qres", q32, 64'd0);
        rst = 0;
        @(negedge clk);

        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 5, res, lat);
        chk("umax_res", res, 64'hFFFF_FFFE_0000_0001);
        chk("umax_latency", 64'(lat), 64'd33);
        chk("bp_ready_after", {63'd0, dr32}, 64'd1);
        op32(32'hFFFF_FFFF, 32'd2, 0, 0, 0, res, lat);
        chk("neg1x2_res", res, 64'hFFFF_FFFF_FFFF_FFFE);
        op32(32'h8000_0000, 32'h8000_0000, 0, 0, 1, res, lat);
        chk("minxmin_res", res, 64'h4000_0000_0000_0000);
        op32(32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 2, res, lat);
        chk("mulhsu_res", res, 64'h8000_0000_8000_0000);

        // flush at iteration 10
        l32 = 32'h1234_5678; r32 = 32'h9ABC_DEF0; ul32 = 1; ur32 = 1; dv32 = 1;
        @(posedge clk);
        @(negedge clk);
        dv32 = 0;
        repeat (9) @(negedge clk);
        fl32 = 1;
        @(negedge clk);
        chk("flush_idle", {63'd0, dr32}, 64'd1);
        dv32 = 1;
        @(negedge clk);
        fl32 = 0; dv32 = 0;
        chk("flush_not_accepted", {63'd0, dr32}, 64'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("flush_no_qvalid", {63'd0, qv32}, 64'd0);
        end

        // asynchronous reset mid-BUSY
        l32 = 32'd7; r32 = 32'd9; dv32 = 1;
        @(posedge clk);
        @(negedge clk);
        dv32 = 0;
        repeat (5) @(negedge clk);
        chk("busy_dready", {63'd0, dr32}, 64'd0);
        #2 rst = 1;
        #1;
        chk("async_rst_dready", {63'd0, dr32}, 64'd1);
        chk("async_rst_qvalid", {63'd0, qv32}, 64'd0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        for (int n = 0; n < 30; n++) begin
            a = $urandom; b = $urandom; ua = $urandom; ub = $urandom;
            if (n < 4) a = 32'h8000_0000;
            if (n % 5 == 1) b = 32'hFFFF_FFFF;
            op32(a, b, ua, ub, $urandom_range(0, 3), res, lat);
            chk("rand32_res", res, ref_mul(a, b, ua, ub, 32));
            chk("rand32_latency", 64'(lat), 64'd33);
        end

        op16(16'hFFFF, 16'hFFFF, 1, 1, 0, res, lat);
        chk("umax16_res", res, 64'h0000_0000_FFFE_0001);
        op16(16'h8000, 16'h8000, 0, 0, 0, res, lat);
        chk("min16_res", res, 64'h0000_0000_4000_0000);
        for (int n = 0; n < 1000; n++) begin
            a = {16'd0, 16'($urandom)}; b = {16'd0, 16'($urandom)};
            ua = $urandom; ub = $urandom;
            op16(a[15:0], b[15:0], ua, ub, $urandom_range(0, 2), res, lat);
            chk("rand16_res", res, ref_mul(a, b, ua, ub, 16));
            chk("rand16_latency", 64'(lat), 64'd5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
